syscall_sequencer: RTL and testbench

// - Services MIPS SYSCALL. Raised by the control unit's syscall flag; stalls the single-cycle core meanwhile.
// - Reads $v0 (service code) and $a0 (argument) from dedicated register-file taps.
// - Borrows the data-memory read port for strings and streams bytes out on a valid/ready channel.
// - Sits beside the control unit; its stall drives PC hold and RegWrite/MemWrite suppression.

---
 rtl/mips_sys_pkg.sv | 22 ++
 rtl/dec_digit_gen.sv | 62 ++++++
 rtl/syscall_sequencer.sv | 146 ++++++++++++++
 tb/tb_syscall_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_sys_pkg.sv
// rtl/mips_sys_pkg.sv - shared service codes, sequencer states and decimal constants for SYSCALL handling
package mips_sys_pkg;

    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // POW10[i] = 10^i
    localparam logic [31:0] POW10 [0:9] = '{
        32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
        32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
    };

    typedef enum logic [2:0] {
        IDLE, DISPATCH, CHAR, STR_RD, STR_OUT, INT, HALT, DONE
    } state_t;

endpackage

// File: rtl/dec_digit_gen.sv
// rtl/dec_digit_gen.sv - unsigned 32-bit to decimal digit stream, one subtraction per cycle
module dec_digit_gen
    import mips_sys_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] val,
    input  logic        digit_ack,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        last
);

    logic [31:0] r_val;
    logic [3:0]  r_idx;
    logic [3:0]  r_digit;
    logic        r_started;
    logic        r_busy;
    logic        r_pend;
    logic [31:0] w_pow;

    assign w_pow       = POW10[r_idx];
    assign digit       = r_digit;
    assign digit_valid = r_pend;
    assign last        = (r_idx == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_val     <= '0;
            r_idx     <= '0;
            r_digit   <= '0;
            r_started <= 1'b0;
            r_busy    <= 1'b0;
            r_pend    <= 1'b0;
        end else if (start) begin
            r_val     <= val;
            r_idx     <= 4'd9;
            r_digit   <= '0;
            r_started <= 1'b0;
            r_busy    <= 1'b1;
            r_pend    <= 1'b0;
        end else if (r_busy && !r_pend) begin
            // leading zeros are skipped, but the units digit is always produced
            if (r_val >= w_pow) begin
                r_val   <= r_val - w_pow;
                r_digit <= r_digit + 4'd1;
            end else if (r_digit != 4'd0 || r_started || r_idx == 4'd0) begin
                r_pend <= 1'b1;
            end else begin
                r_idx <= r_idx - 4'd1;
            end
        end else if (r_pend && digit_ack) begin
            r_pend    <= 1'b0;
            r_started <= 1'b1;
            r_digit   <= '0;
            if (r_idx == 4'd0) r_busy <= 1'b0;
            else               r_idx  <= r_idx - 4'd1;
        end
    end

endmodule

// File: rtl/syscall_sequencer.sv
// rtl/syscall_sequencer.sv - services MIPS SYSCALL (print int/string/char, exit) while stalling the core
module syscall_sequencer
    import mips_sys_pkg::*;
#(
    parameter int MAX_STR_LEN = 256,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              syscall_i,
    input  logic [DATA_W-1:0] v0_i,
    input  logic [DATA_W-1:0] a0_i,
    output logic              stall_o,
    output logic              halt_o,
    output logic              mem_req_o,
    output logic [DATA_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              out_valid_o,
    output logic [7:0]        out_data_o,
    input  logic              out_ready_i,
    output logic              err_o
);

    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    state_t             r_state;
    logic [DATA_W-1:0]  r_code;
    logic [DATA_W-1:0]  r_arg;
    logic [DATA_W-1:0]  r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_int_last;

    logic [7:0]         w_byte;
    logic [DATA_W-1:0]  w_mag;
    logic               w_start;
    logic               w_digit_ack;
    logic [3:0]         w_digit;
    logic               w_digit_valid;
    logic               w_last;
    logic               w_supported;

    assign w_byte      = mem_rdata_i[{r_ptr[1:0], 3'b000} +: 8];
    assign w_mag       = r_arg[DATA_W-1] ? (~r_arg + 1'b1) : r_arg;
    assign w_start     = (r_state == DISPATCH) && (r_code == SVC_PRINT_INT);
    assign w_digit_ack = (r_state == INT) && !r_out_valid && w_digit_valid;
    assign w_supported = (r_code == SVC_PRINT_INT) || (r_code == SVC_PRINT_STR) ||
                         (r_code == SVC_EXIT) || (r_code == SVC_PRINT_CHAR);

    assign stall_o     = (r_state == IDLE) ? syscall_i : (r_state != DONE);
    assign halt_o      = (r_state == HALT);
    assign err_o       = (r_state == DISPATCH) && !w_supported;
    assign mem_req_o   = (r_state == STR_RD);
    assign mem_addr_o  = (r_state == STR_RD) ? {r_ptr[DATA_W-1:2], 2'b00} : '0;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;

    dec_digit_gen u_dec (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (w_start),
        .val         (w_mag),
        .digit_ack   (w_digit_ack),
        .digit       (w_digit),
        .digit_valid (w_digit_valid),
        .last        (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_arg       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_int_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (syscall_i) begin
                    r_code  <= v0_i;
                    r_arg   <= a0_i;
                    r_state <= DISPATCH;
                end
                DISPATCH: begin
                    r_ptr      <= r_arg;
                    r_cnt      <= '0;
                    r_int_last <= 1'b0;
                    case (r_code)
                        SVC_PRINT_INT: begin
                            r_out_data  <= ASCII_MINUS;
                            r_out_valid <= r_arg[DATA_W-1];
                            r_state     <= INT;
                        end
                        SVC_PRINT_STR: r_state <= STR_RD;
                        SVC_EXIT:      r_state <= HALT;
                        SVC_PRINT_CHAR: begin
                            r_out_data  <= r_arg[7:0];
                            r_out_valid <= 1'b1;
                            r_state     <= CHAR;
                        end
                        default:       r_state <= DONE;
                    endcase
                end
                CHAR: if (out_ready_i) begin
                    r_out_valid <= 1'b0;
                    r_state     <= DONE;
                end
                STR_RD: begin
                    if (w_byte == 8'h00 || r_cnt == CNT_W'(MAX_STR_LEN)) begin
                        r_state <= DONE;
                    end else begin
                        r_out_data  <= w_byte;
                        r_out_valid <= 1'b1;
                        r_state     <= STR_OUT;
                    end
                end
                STR_OUT: if (out_ready_i) begin
                    r_out_valid <= 1'b0;
                    r_ptr       <= r_ptr + 1'b1;
                    r_cnt       <= r_cnt + 1'b1;
                    r_state     <= STR_RD;
                end
                INT: begin
                    // '-' (if any) and each digit go out one at a time through r_out_data
                    if (r_out_valid) begin
                        if (out_ready_i) begin
                            r_out_valid <= 1'b0;
                            if (r_int_last) r_state <= DONE;
                        end
                    end else if (w_digit_valid) begin
                        r_out_data  <= ASCII_ZERO + {4'h0, w_digit};
                        r_out_valid <= 1'b1;
                        r_int_last  <= w_last;
                    end
                end
                HALT:    r_state <= HALT;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_sequencer.sv
// tb/tb_syscall_sequencer.sv - directed self-checking bench for syscall_sequencer
module tb_syscall_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        syscall_i = 1'b0;
    logic [31:0] v0_i = '0;
    logic [31:0] a0_i = '0;
    logic        stall_o, halt_o, mem_req_o, out_valid_o, err_o;
    logic [31:0] mem_addr_o, mem_rdata_i;
    logic [7:0]  out_data_o;
    logic        out_ready_i = 1'b1;

    int total = 0;
    int bad = 0;

    logic [7:0]  got_q [$];
    logic [31:0] addr_q [$];
    int          errs, hold_viol, mem_viol, valid_cycles, bp_left;
    bit          hold_pending;
    logic [7:0]  hold_data;
    int          stalls;
    bit          timed_out;
    int          cnt_a, cnt_b;

    syscall_sequencer #(.MAX_STR_LEN(256), .DATA_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .syscall_i   (syscall_i),
        .v0_i        (v0_i),
        .a0_i        (a0_i),
        .stall_o     (stall_o),
        .halt_o      (halt_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1001_0000) return 32'h0069_4855;
        if (a == 32'h1002_0000) return 32'h4100_0000;
        if (a[31:12] == 20'h20000) return 32'h4141_4141;
        return 32'h0;
    endfunction

    assign mem_rdata_i = mem_word(mem_addr_o);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        errs = 0; hold_viol = 0; mem_viol = 0; valid_cycles = 0;
        hold_pending = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        out_ready_i = (bp_left == 0);
        if (out_valid_o && bp_left > 0) bp_left--;
        if (out_valid_o) valid_cycles++;
        if (out_valid_o && out_ready_i) got_q.push_back(out_data_o);
        if (hold_pending && (!out_valid_o || out_data_o != hold_data)) hold_viol++;
        hold_pending = out_valid_o && !out_ready_i;
        hold_data    = out_data_o;
        if (mem_req_o) begin
            addr_q.push_back(mem_addr_o);
            if (out_valid_o) mem_viol++;
        end
        if (err_o) errs++;
    endtask

    task automatic run_sys(input logic [31:0] v0, input logic [31:0] a0, input int bp);
        bp_left = bp;
        out_ready_i = (bp == 0);
        clear_mon();
        v0_i = v0; a0_i = a0; syscall_i = 1'b1;
        #1;
        stalls = stall_o ? 1 : 0;
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!stall_o) begin
                timed_out = 1'b0;
                break;
            end
            stalls++;
        end
        syscall_i = 1'b0;
        step();
    endtask

    task automatic check_str(input string tag, input string exp);
        check_eq($sformatf("%s timeout", tag), 32'(timed_out), 32'd0);
        check_eq($sformatf("%s nbytes", tag), got_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < got_q.size(); i++)
            check_eq($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp[i]));
        check_eq($sformatf("%s hold", tag), hold_viol, 0);
        check_eq($sformatf("%s err", tag), errs, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " stall"}, 32'(stall_o), 0);
        check_eq({tag, " halt"}, 32'(halt_o), 0);
        check_eq({tag, " mem_req"}, 32'(mem_req_o), 0);
        check_eq({tag, " mem_addr"}, mem_addr_o, 0);
        check_eq({tag, " valid"}, 32'(out_valid_o), 0);
        check_eq({tag, " data"}, 32'(out_data_o), 0);
        check_eq({tag, " err"}, 32'(err_o), 0);
    endtask

    initial begin
        bp_left = 0;
        clear_mon();
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_sys(32'd11, 32'h41, 3);
        check_str("char_bp", "A");
        check_eq("char_bp stalls", stalls, 6);
        check_eq("char_bp held", valid_cycles, 4);

        run_sys(32'd11, 32'h5A, 0);
        check_str("char", "Z");
        check_eq("char stalls", stalls, 3);

        run_sys(32'd1, 32'hFFFF_FECF, 0);
        check_str("int_neg305", "-305");
        run_sys(32'd1, 32'd0, 0);
        check_str("int_zero", "0");
        run_sys(32'd1, 32'h8000_0000, 0);
        check_str("int_min", "-2147483648");
        run_sys(32'd1, 32'd100, 2);
        check_str("int_100", "100");

        run_sys(32'd4, 32'h1001_0001, 0);
        check_str("str_hi", "Hi");
        check_eq("str_hi nreads", addr_q.size(), 3);
        for (int i = 0; i < addr_q.size(); i++)
            check_eq($sformatf("str_hi addr%0d", i), addr_q[i], 32'h1001_0000);
        check_eq("str_hi memreq", mem_viol, 0);

        run_sys(32'd4, 32'h1002_0003, 1);
        check_str("str_cross", "A");
        check_eq("str_cross nreads", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            check_eq("str_cross addr0", addr_q[0], 32'h1002_0000);
            check_eq("str_cross addr1", addr_q[1], 32'h1002_0004);
        end
        check_eq("str_cross memreq", mem_viol, 0);

        run_sys(32'd4, 32'h2000_0000, 0);
        check_eq("str_max timeout", 32'(timed_out), 0);
        check_eq("str_max nbytes", got_q.size(), 256);
        cnt_a = 0;
        foreach (got_q[i]) if (got_q[i] != 8'h41) cnt_a++;
        check_eq("str_max content", cnt_a, 0);

        run_sys(32'd99, 32'd7, 0);
        check_eq("bad_code timeout", 32'(timed_out), 0);
        check_eq("bad_code err", errs, 1);
        check_eq("bad_code nbytes", got_q.size(), 0);
        check_eq("bad_code stalls", stalls, 2);

        bp_left = 0;
        clear_mon();
        v0_i = 32'd4; a0_i = 32'h2000_0000; syscall_i = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_eq("mid_str busy", got_q.size() > 0, 1);
        #2;
        reset_n = 1'b0;
        syscall_i = 1'b0;
        #1;
        check_idle_outputs("mid_str reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_sys(32'd11, 32'h42, 0);
        check_str("after_reset", "B");
        check_eq("after_reset stalls", stalls, 3);

        clear_mon();
        v0_i = 32'd10; a0_i = 32'd0; syscall_i = 1'b1;
        cnt_a = 0; cnt_b = 0;
        step();
        for (int i = 0; i < 100; i++) begin
            step();
            if (stall_o) cnt_a++;
            if (halt_o) cnt_b++;
        end
        check_eq("halt stall", cnt_a, 100);
        check_eq("halt sticky", cnt_b, 100);
        check_eq("halt nbytes", got_q.size(), 0);
        #2;
        reset_n = 1'b0;
        syscall_i = 1'b0;
        #1;
        check_idle_outputs("halt reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
